// File: rtl/vx_tcu_fedp_seq.sv
// Sequencer for a fused element-wise dot-product (FEDP) datapath.
// Accepts a job (k steps, formats, initial accumulator, tag), feeds k operand
// pairs through the attached LATENCY-deep datapath one at a time, chains each
// step's result into the next step's c input, then returns the final value.
module vx_tcu_fedp_seq #(
    parameter int N       = 2,
    parameter int LATENCY = 4,
    parameter int KW      = 8,
    parameter int TAGW    = 4,
    parameter int XLEN    = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [KW-1:0]     req_k,
    input  logic [2:0]        req_fmt_s,
    input  logic [2:0]        req_fmt_d,
    input  logic [XLEN-1:0]   req_c,
    input  logic [TAGW-1:0]   req_tag,

    input  logic              op_valid,
    output logic              op_ready,
    input  logic [N*XLEN-1:0] op_a,
    input  logic [N*XLEN-1:0] op_b,

    output logic              fedp_enable,
    output logic [2:0]        fedp_fmt_s,
    output logic [2:0]        fedp_fmt_d,
    output logic [N*XLEN-1:0] fedp_a_row,
    output logic [N*XLEN-1:0] fedp_b_col,
    output logic [XLEN-1:0]   fedp_c_val,
    input  logic [XLEN-1:0]   fedp_d_val,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_d,
    output logic [TAGW-1:0]   rsp_tag
);

    // Wait counter must hold the value LATENCY itself.
    localparam int WCW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RSP   = 2'd3;

    logic [1:0]      state;
    logic [KW-1:0]   remaining;
    logic [WCW-1:0]  wait_cnt;
    logic [XLEN-1:0] acc;
    logic [2:0]      fmt_s;
    logic [2:0]      fmt_d;
    logic [TAGW-1:0] tag;

    logic req_fire;
    logic op_fire;
    logic rsp_fire;
    logic capture;

    // Handshakes and datapath controls are pure functions of the current state.
    always_comb begin
        req_ready   = (state == IDLE);
        op_ready    = (state == ISSUE);
        rsp_valid   = (state == RSP);
        req_fire    = req_valid & req_ready;
        op_fire     = op_valid & op_ready;
        rsp_fire    = rsp_valid & rsp_ready;
        // The last wait cycle is the capture cycle: the result sits at the
        // datapath output and the pipeline must not advance past it.
        capture     = (state == WAIT) && (wait_cnt == WCW'(1));
        fedp_enable = op_fire || ((state == WAIT) && (wait_cnt > WCW'(1)));
        fedp_a_row  = op_a;
        fedp_b_col  = op_b;
        fedp_c_val  = acc;
        fedp_fmt_s  = fmt_s;
        fedp_fmt_d  = fmt_d;
        rsp_d       = acc;
        rsp_tag     = tag;
    end

    // Job sequencer: accept request, issue k steps with fixed-latency waits, respond.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            remaining <= '0;
            wait_cnt  <= '0;
            acc       <= '0;
            fmt_s     <= '0;
            fmt_d     <= '0;
            tag       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        remaining <= req_k;
                        fmt_s     <= req_fmt_s;
                        fmt_d     <= req_fmt_d;
                        tag       <= req_tag;
                        acc       <= req_c;
                        state     <= (req_k == '0) ? RSP : ISSUE;
                    end
                end
                ISSUE: begin
                    if (op_fire) begin
                        remaining <= remaining - KW'(1);
                        wait_cnt  <= WCW'(LATENCY);
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - WCW'(1);
                    if (capture) begin
                        acc   <= fedp_d_val;
                        state <= (remaining != '0) ? ISSUE : RSP;
                    end
                end
                default: begin
                    if (rsp_fire) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vx_tcu_fedp_seq.sv
// Scoreboard bench for vx_tcu_fedp_seq with a behavioral fp16 FEDP datapath.
module tb_vx_tcu_fedp_seq;

    localparam int N    = 2;
    localparam int LAT  = 4;
    localparam int KW   = 8;
    localparam int TAGW = 4;
    localparam int XLEN = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [KW-1:0]     req_k;
    logic [2:0]        req_fmt_s;
    logic [2:0]        req_fmt_d;
    logic [XLEN-1:0]   req_c;
    logic [TAGW-1:0]   req_tag;
    logic              op_valid;
    logic              op_ready;
    logic [N*XLEN-1:0] op_a;
    logic [N*XLEN-1:0] op_b;
    logic              fedp_enable;
    logic [2:0]        fedp_fmt_s;
    logic [2:0]        fedp_fmt_d;
    logic [N*XLEN-1:0] fedp_a_row;
    logic [N*XLEN-1:0] fedp_b_col;
    logic [XLEN-1:0]   fedp_c_val;
    logic [XLEN-1:0]   fedp_d_val;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_d;
    logic [TAGW-1:0]   rsp_tag;

    vx_tcu_fedp_seq #(.N(N), .LATENCY(LAT), .KW(KW), .TAGW(TAGW), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_k(req_k),
        .req_fmt_s(req_fmt_s), .req_fmt_d(req_fmt_d), .req_c(req_c), .req_tag(req_tag),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .fedp_enable(fedp_enable), .fedp_fmt_s(fedp_fmt_s), .fedp_fmt_d(fedp_fmt_d),
        .fedp_a_row(fedp_a_row), .fedp_b_col(fedp_b_col), .fedp_c_val(fedp_c_val),
        .fedp_d_val(fedp_d_val),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_d(rsp_d), .rsp_tag(rsp_tag)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioral FEDP model (fp16 inputs, fp32 accumulate) ----------------
    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        real r;
        if (h[14:10] == 5'd0) return 0.0;
        r = (1.0 + real'(h[9:0]) / 1024.0) * pow2(int'(h[14:10]) - 15);
        return h[15] ? -r : r;
    endfunction

    function automatic real s2r(input logic [31:0] s);
        real r;
        if (s[30:23] == 8'd0) return 0.0;
        r = (1.0 + real'(s[22:0]) / 8388608.0) * pow2(int'(s[30:23]) - 127);
        return s[31] ? -r : r;
    endfunction

    function automatic logic [31:0] r2s(input real v);
        logic sgn;
        int   e;
        int   m;
        logic [31:0] res;
        if (v == 0.0) return 32'd0;
        sgn = (v < 0.0);
        if (sgn) v = -v;
        e = 127;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0)  begin v = v * 2.0; e--; end
        m = $rtoi((v - 1.0) * 8388608.0 + 0.5);
        res = {sgn, e[7:0], m[22:0]};
        return res;
    endfunction

    function automatic logic [31:0] fedp(input logic [N*XLEN-1:0] a, input logic [N*XLEN-1:0] b,
                                         input logic [31:0] c);
        real sum = s2r(c);
        for (int i = 0; i < N * XLEN / 16; i++) sum = sum + h2r(a[16*i +: 16]) * h2r(b[16*i +: 16]);
        return r2s(sum);
    endfunction

    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        if (fedp_enable) begin
            pipe[0] <= fedp(fedp_a_row, fedp_b_col, fedp_c_val);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign fedp_d_val = pipe[LAT-1];

    // ---------------- scoreboard + monitor ----------------
    logic [31:0]     exp_d[$];
    logic [TAGW-1:0] exp_tag[$];
    int unsigned     iss_cyc[$];
    logic [31:0]     iss_c[$];
    int              pops = 0;
    int unsigned     rsp_first = 0;
    int              en_cnt = 0;
    logic            prev_valid = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            if (fedp_enable) en_cnt++;
            if (op_valid && op_ready) begin
                iss_cyc.push_back(cyc);
                iss_c.push_back(fedp_c_val);
            end
            if (rsp_valid && !prev_valid) rsp_first = cyc;
            if (rsp_valid && rsp_ready) begin
                if (exp_d.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got d=0x%08h tag=%0d expected no response", rsp_d, rsp_tag);
                end else begin
                    chk("rsp_d", rsp_d, exp_d.pop_front());
                    chk("rsp_tag", 32'(rsp_tag), 32'(exp_tag.pop_front()));
                end
                pops++;
            end
        end
        prev_valid = reset && rsp_valid;
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_req(input logic [KW-1:0] k, input logic [31:0] c, input logic [TAGW-1:0] t,
                          input logic expect_rsp, input logic [31:0] d_exp);
        int n = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_k = k; req_c = c; req_tag = t;
        req_fmt_s = 3'd2; req_fmt_d = 3'd1;
        @(negedge clk);
        while (!req_ready && n < 200) begin n++; @(negedge clk); end
        if (!req_ready) begin checks++; errors++; $display("FAIL req_accept: req_ready stuck 0 expected 1"); end
        if (expect_rsp) begin exp_d.push_back(d_exp); exp_tag.push_back(t); end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (pops < target && n < 5000) begin n++; @(negedge clk); end
        if (pops < target) begin checks++; errors++; $display("FAIL rsp_timeout: got %0d responses expected %0d", pops, target); end
    endtask

    task automatic chk_reset_outputs(input string tag_s);
        chk({tag_s, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag_s, "_op_ready"}, 32'(op_ready), 32'd0);
        chk({tag_s, "_fedp_enable"}, 32'(fedp_enable), 32'd0);
        chk({tag_s, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag_s, "_rsp_d"}, rsp_d, 32'd0);
        chk({tag_s, "_rsp_tag"}, 32'(rsp_tag), 32'd0);
        chk({tag_s, "_c_val"}, fedp_c_val, 32'd0);
        chk({tag_s, "_fmts"}, {26'd0, fedp_fmt_s, fedp_fmt_d}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        reset = 1'b0; req_valid = 1'b0; req_k = '0; req_c = '0; req_tag = '0;
        req_fmt_s = '0; req_fmt_d = '0; op_valid = 1'b0; rsp_ready = 1'b1;
        op_a = 64'h3C003C00_3C003C00;
        op_b = 64'h3C003C00_3C003C00;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1 reset = 1'b1;

        // k=1: 1.0 + 4*1*1 = 5.0
        op_valid = 1'b1;
        iss_cyc.delete(); iss_c.delete(); en_cnt = 0;
        do_req(8'd1, 32'h3F800000, 4'd1, 1'b1, 32'h40A00000);
        @(negedge clk);
        chk("fmt_pass", {26'd0, fedp_fmt_s, fedp_fmt_d}, {26'd0, 3'd2, 3'd1});
        wait_done(1);
        chk("k1_issue_to_rsp", rsp_first - iss_cyc[0], LAT + 1);
        chk("k1_enable_cycles", en_cnt, LAT);

        // k=3 with operands always valid: 13.0, issues every LAT+1 cycles
        iss_cyc.delete(); iss_c.delete();
        do_req(8'd3, 32'h3F800000, 4'd2, 1'b1, 32'h41500000);
        wait_done(2);
        chk("k3_issues", iss_cyc.size(), 3);
        if (iss_cyc.size() == 3) begin
            chk("k3_spacing1", iss_cyc[1] - iss_cyc[0], LAT + 1);
            chk("k3_spacing2", iss_cyc[2] - iss_cyc[1], LAT + 1);
            chk("k3_c_issue2", iss_c[1], 32'h40A00000);
            chk("k3_c_issue3", iss_c[2], 32'h41100000);
        end

        // k=0: direct response on the next cycle, no operand traffic
        iss_cyc.delete();
        do_req(8'd0, 32'h12345678, 4'd5, 1'b1, 32'h12345678);
        @(negedge clk);
        chk("k0_rsp_valid_next", 32'(rsp_valid), 32'd1);
        chk("k0_op_ready", 32'(op_ready), 32'd0);
        wait_done(3);
        chk("k0_no_issue", iss_cyc.size(), 0);

        // k=2 with operand stall and response backpressure: 9.0
        op_valid = 1'b0; rsp_ready = 1'b0;
        do_req(8'd2, 32'h3F800000, 4'd9, 1'b1, 32'h41100000);
        n = 0;
        while (!op_ready && n < 50) begin n++; @(negedge clk); end
        for (int i = 0; i < 3; i++) begin
            chk("stall_enable", 32'(fedp_enable), 32'd0);
            chk("stall_op_ready", 32'(op_ready), 32'd1);
            @(negedge clk);
        end
        op_valid = 1'b1;
        n = 0;
        while (!rsp_valid && n < 100) begin n++; @(negedge clk); end
        for (int i = 0; i < 6; i++) begin
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_d", rsp_d, 32'h41100000);
            chk("hold_rsp_tag", 32'(rsp_tag), 32'd9);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("fire_req_ready", 32'(req_ready), 32'd0);
        wait_done(4);

        // k=255 runs every step without wrapping: 255*4 = 1020.0
        iss_cyc.delete();
        do_req(8'd255, 32'h00000000, 4'd3, 1'b1, 32'h447F0000);
        wait_done(5);
        chk("k255_issues", iss_cyc.size(), 255);

        // reset two cycles after an op fire aborts the job silently
        iss_cyc.delete();
        base = pops;
        do_req(8'd3, 32'h3F800000, 4'd7, 1'b0, 32'h0);
        n = 0;
        while (iss_cyc.size() == 0 && n < 50) begin n++; @(negedge clk); end
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk_reset_outputs("abort");
        @(posedge clk); @(posedge clk); #1 reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        do_req(8'd1, 32'h3F800000, 4'd4, 1'b1, 32'h40A00000);
        wait_done(base + 1);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
